// File: rtl/seg_capture.sv
// Rebuilds BCD digits from a multiplexed 7-segment bus: input registers, a
// stability filter, pattern decode and per-digit result slots with a frame strobe.
module seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    inv,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic                    frame_valid,
    output logic                    err
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

    logic [7:0]            seg_reg, seg_prev_reg;
    logic [NUM_DIGITS-1:0] dig_reg, dig_prev_reg;
    logic [CW-1:0]         cnt_reg;
    logic [NUM_DIGITS-1:0] mask_reg;
    logic                  frame_valid_reg;
    logic                  err_reg;
    logic [3:0]            bcd_reg [NUM_DIGITS];
    logic                  dp_reg  [NUM_DIGITS];

    logic [7:0]            seg_act;
    logic                  same_pair;
    logic                  one_hot;
    logic                  accept;
    logic [3:0]            decoded;
    logic [NUM_DIGITS-1:0] mask_next;

    assign seg_act   = inv ? seg_reg : ~seg_reg;
    assign same_pair = (seg_reg == seg_prev_reg) && (dig_reg == dig_prev_reg);
    assign one_hot   = (dig_reg != '0) && ((dig_reg & (dig_reg - DIG_ONE)) == '0);
    // Fires only on the transition into saturation, so a held pattern accepts once.
    assign accept    = en && same_pair && one_hot && (cnt_reg == CNT_PRE);
    assign mask_next = mask_reg | dig_reg;

    always_comb begin
        decoded = 4'hF;
        case (seg_act[6:0])
            7'h3F: decoded = 4'd0;
            7'h06: decoded = 4'd1;
            7'h5B: decoded = 4'd2;
            7'h4F: decoded = 4'd3;
            7'h66: decoded = 4'd4;
            7'h6D: decoded = 4'd5;
            7'h7D: decoded = 4'd6;
            7'h07: decoded = 4'd7;
            7'h7F: decoded = 4'd8;
            7'h6F: decoded = 4'd9;
            7'h00: decoded = 4'hE;
            default: decoded = 4'hF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg      <= '0;
            dig_reg      <= '0;
            seg_prev_reg <= '0;
            dig_prev_reg <= '0;
        end else begin
            seg_reg      <= seg_in;
            dig_reg      <= dig_en;
            seg_prev_reg <= seg_reg;
            dig_prev_reg <= dig_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_reg <= '0;
        end else if (same_pair && one_hot) begin
            cnt_reg <= (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
        end else begin
            cnt_reg <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            mask_reg        <= '0;
            frame_valid_reg <= 1'b0;
        end else if (accept && (&mask_next)) begin
            mask_reg        <= '0;
            frame_valid_reg <= 1'b1;
        end else begin
            mask_reg        <= accept ? mask_next : mask_reg;
            frame_valid_reg <= 1'b0;
        end
    end

    // An illegal accept in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (accept && (decoded == 4'hF)) begin
            err_reg <= 1'b1;
        end else if (err_clr) begin
            err_reg <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst) begin
                bcd_reg[gi] <= 4'hE;
                dp_reg[gi]  <= 1'b0;
            end else if (accept && dig_reg[gi]) begin
                bcd_reg[gi] <= decoded;
                dp_reg[gi]  <= seg_act[7];
            end
        end
        assign bcd_out[4*gi +: 4] = bcd_reg[gi];
        assign dp_out[gi]         = dp_reg[gi];
    end

    assign frame_valid = frame_valid_reg;
    assign err         = err_reg;
endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture (NUM_DIGITS=4, STABLE_CYCLES=4) with
// hand-computed expectations checked by immediate assertions.
module tb_seg_capture;
    logic        clk = 1'b0;
    logic        rst, en, inv, err_clr;
    logic [7:0]  seg_in;
    logic [3:0]  dig_en;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic        frame_valid, err;

    int errors = 0;
    int checks = 0;
    int frame_cnt = 0;
    logic [15:0] frame_bcd = 16'h0;
    int fc0;
    logic [15:0] snap;

    seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .inv(inv), .seg_in(seg_in),
        .dig_en(dig_en), .err_clr(err_clr), .bcd_out(bcd_out),
        .dp_out(dp_out), .frame_valid(frame_valid), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (frame_valid) begin
            frame_cnt++;
            frame_bcd = bcd_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [7:0] s, input logic [3:0] d, input int n);
        seg_in = s;
        dig_en = d;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; inv = 1'b1; err_clr = 1'b0;
        seg_in = 8'h00; dig_en = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(bcd_out), 32'h0000EEEE);
        chk("rst_dp", 32'(dp_out), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        // inv=1: digits 0..3 show 1,2,3,4
        drive(8'h06, 4'b0001, 10);
        drive(8'h5B, 4'b0010, 10);
        drive(8'h4F, 4'b0100, 10);
        drive(8'h66, 4'b1000, 10);
        chk("f1_bcd", 32'(bcd_out), 32'h4321);
        chk("f1_frames", frame_cnt, 1);
        chk("f1_frame_bcd", 32'(frame_bcd), 32'h4321);
        chk("f1_err", 32'(err), 32'h0);

        // inv=0: digit 2 pattern 0 with dp line low; short hold does nothing
        inv = 1'b0;
        drive(8'hFF, 4'b0000, 2);
        drive(8'h40, 4'b0100, 3);
        drive(8'hFF, 4'b0000, 6);
        chk("short_hold", 32'(bcd_out), 32'h4321);
        drive(8'h40, 4'b0100, 5);
        chk("lat_n_plus_1", 32'(bcd_out), 32'h4321);
        @(negedge clk);
        chk("lat_n_plus_2", 32'(bcd_out), 32'h4021);
        chk("dp2", 32'(dp_out), 32'h4);
        drive(8'h40, 4'b0100, 4);

        // illegal pattern 0x49 on digit 1 (line = ~0x49 = 0xB6)
        drive(8'hB6, 4'b0010, 10);
        chk("ill_bcd", 32'(bcd_out), 32'h40F1);
        chk("ill_err", 32'(err), 32'h1);
        drive(8'hFF, 4'b0000, 2);
        drive(8'hB6, 4'b0001, 5);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("set_wins_err", 32'(err), 32'h1);
        chk("set_wins_bcd", 32'(bcd_out), 32'h40FF);
        drive(8'hB6, 4'b0001, 3);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 32'h0);

        // non-one-hot enables never accept
        fc0 = frame_cnt;
        snap = bcd_out;
        drive(8'hF9, 4'b0011, 20);
        chk("multi_bcd", 32'(bcd_out), 32'(snap));
        drive(8'hF9, 4'b0000, 20);
        chk("zero_bcd", 32'(bcd_out), 32'(snap));
        chk("nonhot_frames", frame_cnt, fc0);
        chk("nonhot_err", 32'(err), 32'h0);

        // clear partial mask, then digit 0 twice (5 then 6), digits 1..3 = 7,8,9
        en = 1'b0;
        drive(8'hFF, 4'b0000, 2);
        en = 1'b1;
        fc0 = frame_cnt;
        drive(8'h92, 4'b0001, 10);
        drive(8'h82, 4'b0001, 10);
        chk("rewrite_nofr", frame_cnt, fc0);
        drive(8'hF8, 4'b0010, 10);
        drive(8'h80, 4'b0100, 10);
        drive(8'h90, 4'b1000, 10);
        chk("f2_bcd", 32'(bcd_out), 32'h9876);
        chk("f2_frames", frame_cnt, fc0 + 1);
        chk("f2_frame_bcd", 32'(frame_bcd), 32'h9876);
        chk("f2_dp", 32'(dp_out), 32'h0);

        // en=0 mid-frame discards the partial mask
        fc0 = frame_cnt;
        drive(8'hF9, 4'b0001, 10);
        drive(8'hA4, 4'b0010, 10);
        en = 1'b0;
        drive(8'hB0, 4'b0100, 8);
        chk("en0_hold", 32'(bcd_out), 32'h9821);
        en = 1'b1;
        drive(8'hB0, 4'b0100, 10);
        drive(8'h99, 4'b1000, 10);
        chk("en0_nofr", frame_cnt, fc0);
        chk("en0_bcd", 32'(bcd_out), 32'h4321);
        drive(8'hF9, 4'b0001, 10);
        drive(8'hA4, 4'b0010, 10);
        chk("en0_frame", frame_cnt, fc0 + 1);

        // reset after two slots updated
        drive(8'h92, 4'b0001, 10);
        drive(8'h82, 4'b0010, 10);
        chk("pre_rst_bcd", 32'(bcd_out), 32'h4365);
        rst = 1'b1;
        drive(8'hFF, 4'b0000, 1);
        rst = 1'b0;
        chk("mid_rst_bcd", 32'(bcd_out), 32'h0000EEEE);
        chk("mid_rst_dp", 32'(dp_out), 32'h0);
        fc0 = frame_cnt;
        drive(8'h80, 4'b0100, 10);
        drive(8'h90, 4'b1000, 10);
        chk("rst_mask_clr", frame_cnt, fc0);
        drive(8'hC0, 4'b0001, 10);
        drive(8'hF9, 4'b0010, 10);
        chk("post_rst_fr", frame_cnt, fc0 + 1);
        chk("post_rst_bcd", 32'(bcd_out), 32'h9810);
        chk("final_fv", 32'(frame_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
